assert_explicit_sequence: RTL and testbench

Request/grant block with a built-in protocol checker. `gnt` is a registered copy of `req`, delayed by one clock. An embedded monitor checks each clock that every request is a single-cycle pulse answered by a single-cycle grant, and reports any violation at simulation time. It serves as a leaf grant generator and as a self-checking example of an explicit two-step sequence check.

---
 rtl/assert_explicit_sequence.sv | 53 +++++
 tb/tb_assert_explicit_sequence.sv | 135 +++++++++++++
 2 files changed

// File: rtl/assert_explicit_sequence.sv
`timescale 1ns/1ps
// Leaf grant generator: gnt is req registered one clock, async active-high reset.
// An embedded two-stage monitor checks each request as pulse -> grant pulse -> idle.
module assert_explicit_sequence (
   input  logic clk,
   input  logic req,
   input  logic reset,
   output logic gnt
);
   logic gnt_q, gnt_d;
   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic step1_ok, step2_ok;
   logic step1_fail, step2_fail;

   // s1/s2 track attempts one and two edges old; both are cleared by reset,
   // so no failure can be flagged while reset is high.
   always_comb begin
      gnt_d      = req;
      step1_ok   = !req && gnt_q;
      step2_ok   = !req && !gnt_q;
      s1_d       = req;
      s2_d       = s1_q && step1_ok;
      step1_fail = s1_q && !step1_ok;
      step2_fail = s2_q && !step2_ok;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt_q <= 1'b0;
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
      end else begin
         gnt_q <= gnt_d;
         s1_q  <= s1_d;
         s2_q  <= s2_d;
      end
   end

   assign gnt = gnt_q;

`ifndef SYNTHESIS
   // One report per failing attempt; both stages may report at the same edge.
   always @(posedge clk) begin
      if (step1_fail) $display("@%0tns Assertion Failed", $time);
      if (step2_fail) $display("@%0tns Assertion Failed", $time);
`ifdef ASSERT_VERBOSE
      if (s2_q && step2_ok) $display("@%0tns Assertion Passed", $time);
`endif
   end
`endif

endmodule

// File: tb/tb_assert_explicit_sequence.sv
`timescale 1ns/1ps
// Bench for assert_explicit_sequence: directed scenarios then random traffic,
// checked against an attempt-level model built from the request history.
module tb_assert_explicit_sequence;
   logic clk = 1'b0;
   logic req = 1'b0;
   logic reset = 1'b1;
   logic gnt;

   int n_checks = 0;
   int n_pass   = 0;
   int rpt_obs  = 0;
   int r_hist[$];

   assert_explicit_sequence dut (
      .clk   (clk),
      .req   (req),
      .reset (reset),
      .gnt   (gnt)
   );

   always #3 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic logic [7:0] reports_now();
      return 8'(dut.step1_fail) + 8'(dut.step2_fail);
   endfunction

   // Called at a falling edge: drive req, predict reports at the coming edge,
   // then check gnt after the edge.
   task automatic step(input logic r, input string tag);
      int n, exp_f, g_now, g_prev;
      logic [7:0] obs;
      req = r;
      #2;
      n      = r_hist.size();
      g_now  = (n >= 1) ? r_hist[n-1] : 0;   // gnt seen at this edge = req one edge ago
      g_prev = (n >= 2) ? r_hist[n-2] : 0;
      exp_f  = 0;
      // attempt started one edge ago: wants req low, gnt high
      if (n >= 1 && r_hist[n-1] == 1 && !(r == 0 && g_now == 1)) exp_f++;
      // attempt started two edges ago that survived step 1: wants req low, gnt low
      if (n >= 2 && r_hist[n-2] == 1 && r_hist[n-1] == 0 && g_prev == 1 &&
          !(r == 0 && g_now == 0)) exp_f++;
      obs = reports_now();
      rpt_obs += int'(obs);
      check({tag, "_rpt"}, obs, 8'(exp_f));
      @(posedge clk);
      #1;
      r_hist.push_back(int'(r));
      check({tag, "_gnt"}, {7'd0, gnt}, {7'd0, r});
      @(negedge clk);
   endtask

   // Called at a falling edge: async reset between edges, released after one edge.
   task automatic mid_reset(input string tag);
      #1 reset = 1'b1;
      #1;
      check({tag, "_gnt_now"}, {7'd0, gnt}, 8'd0);
      check({tag, "_rpt_now"}, reports_now(), 8'd0);
      r_hist.delete();
      @(posedge clk);
      #1;
      check({tag, "_gnt_held"}, {7'd0, gnt}, 8'd0);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      // reset for 20 ns with a request pulse inside it
      #1;
      check("rst_gnt0", {7'd0, gnt}, 8'd0);
      #3 req = 1'b1;
      #4;
      check("rst_gnt1", {7'd0, gnt}, 8'd0);
      check("rst_rpt1", reports_now(), 8'd0);
      #2;
      check("rst_gnt2", {7'd0, gnt}, 8'd0);
      #2 req = 1'b0;
      #4;
      check("rst_gnt3", {7'd0, gnt}, 8'd0);
      check("rst_rpt3", reports_now(), 8'd0);
      #4 reset = 1'b0;
      @(negedge clk);

      // single pulse: one grant cycle, no reports
      rpt_obs = 0;
      step(1'b1, "single_a"); step(1'b0, "single_b"); step(1'b0, "single_c");
      check("single_total", 8'(rpt_obs), 8'd0);

      // held for two edges: one report
      rpt_obs = 0;
      step(1'b1, "held_a"); step(1'b1, "held_b"); step(1'b0, "held_c"); step(1'b0, "held_d");
      check("held_total", 8'(rpt_obs), 8'd1);

      // back-to-back 1,0,1,0: first attempt fails step 2, second passes
      rpt_obs = 0;
      step(1'b1, "b2b_a"); step(1'b0, "b2b_b"); step(1'b1, "b2b_c");
      step(1'b0, "b2b_d"); step(1'b0, "b2b_e");
      check("b2b_total", 8'(rpt_obs), 8'd1);

      // reset mid-attempt: grant drops at once, aborted attempt not reported
      rpt_obs = 0;
      step(1'b1, "mrst_a");
      mid_reset("mrst");
      step(1'b0, "mrst_b"); step(1'b0, "mrst_c");
      check("mrst_total", 8'(rpt_obs), 8'd0);

      // long hold of four edges: three reports
      rpt_obs = 0;
      step(1'b1, "long_a"); step(1'b1, "long_b"); step(1'b1, "long_c"); step(1'b1, "long_d");
      step(1'b0, "long_e"); step(1'b0, "long_f");
      check("long_total", 8'(rpt_obs), 8'd3);

      // random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) mid_reset("rnd_rst");
         else step(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
